// File: rtl/modulator_am_if.sv
// Sample/config/PWM bundle between the sample source, the AM modulator and the pin driver.
interface modulator_am_if;
    logic       enable;
    logic [7:0] bits_per_sample;
    logic [7:0] clks_per_pwm_step;
    logic       new_sample;
    logic [7:0] sample;
    logic       pwm;

    modport master (
        output enable, bits_per_sample, clks_per_pwm_step, new_sample, sample,
        input  pwm
    );

    modport slave (
        input  enable, bits_per_sample, clks_per_pwm_step, new_sample, sample,
        output pwm
    );
endinterface

// File: rtl/modulator_am.sv
// Single-channel AM/PWM modulator: duty follows the captured 8-bit sample and,
// like the step/clock configuration, only changes at a PWM period boundary.
module modulator_am #(
    parameter int FOO                  = 1,
    parameter int AM_CLKS_IN_PWM_STEPS = 2,
    parameter int AM_PWM_STEPS         = 255
) (
    input  logic          clk,
    input  logic          rst,
    modulator_am_if.slave bus
);
    localparam logic [7:0] DEF_C = 8'(AM_CLKS_IN_PWM_STEPS);
    localparam logic [7:0] DEF_N = 8'(AM_PWM_STEPS);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t     state, state_d;
    logic [7:0] clk_cnt, clk_cnt_d;
    logic [7:0] step_cnt, step_cnt_d;
    logic [7:0] pending, pending_d;
    logic [7:0] duty, duty_d;
    logic [7:0] n_lat, n_lat_d;
    logic [7:0] c_lat, c_lat_d;
    logic       pwm_q, pwm_d;
    logic [7:0] in_n, in_c, cur_n, cur_c;
    logic       at_step_end, at_boundary;
    logic       unused_foo;

    assign unused_foo = (FOO != 0);
    assign bus.pwm    = pwm_q;

    always_comb begin
        in_n = (bus.bits_per_sample == 8'd0) ? DEF_N : bus.bits_per_sample;
        in_c = (bus.clks_per_pwm_step == 8'd0) ? DEF_C : bus.clks_per_pwm_step;

        // The first enabled cycle runs on the live inputs, later cycles on the latched copy
        cur_n = (state == ST_IDLE) ? in_n : n_lat;
        cur_c = (state == ST_IDLE) ? in_c : c_lat;

        at_step_end = (clk_cnt == (cur_c - 8'd1));
        at_boundary = at_step_end && (step_cnt == (cur_n - 8'd1));

        state_d    = state;
        clk_cnt_d  = clk_cnt;
        step_cnt_d = step_cnt;
        duty_d     = duty;
        n_lat_d    = n_lat;
        c_lat_d    = c_lat;
        pwm_d      = 1'b0;
        pending_d  = bus.new_sample ? bus.sample : pending;

        if (!bus.enable) begin
            state_d    = ST_IDLE;
            clk_cnt_d  = 8'd0;
            step_cnt_d = 8'd0;
        end else begin
            state_d = ST_RUN;
            pwm_d   = (step_cnt < duty);
            if (state == ST_IDLE) begin
                n_lat_d = in_n;
                c_lat_d = in_c;
            end
            if (at_step_end) begin
                clk_cnt_d  = 8'd0;
                step_cnt_d = at_boundary ? 8'd0 : step_cnt + 8'd1;
            end else begin
                clk_cnt_d  = clk_cnt + 8'd1;
            end
            // A strobe on this same edge lands in pending and waits for the next boundary
            if (at_boundary) begin
                duty_d  = pending;
                n_lat_d = in_n;
                c_lat_d = in_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            clk_cnt  <= 8'd0;
            step_cnt <= 8'd0;
            pending  <= 8'd0;
            duty     <= 8'd0;
            n_lat    <= DEF_N;
            c_lat    <= DEF_C;
            pwm_q    <= 1'b0;
        end else begin
            state    <= state_d;
            clk_cnt  <= clk_cnt_d;
            step_cnt <= step_cnt_d;
            pending  <= pending_d;
            duty     <= duty_d;
            n_lat    <= n_lat_d;
            c_lat    <= c_lat_d;
            pwm_q    <= pwm_d;
        end
    end
endmodule

// File: tb/tb_modulator_am.sv
// Self-checking bench for modulator_am: per-period high-time scoreboard on a default
// instance and on a second instance exercising the parameter fallbacks.
module tb_modulator_am;
    logic clk = 1'b0;
    logic rst;
    logic use_fb = 1'b0;
    logic pwm_obs;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];

    modulator_am_if mb ();
    modulator_am_if fb ();

    modulator_am dut_main (
        .clk (clk),
        .rst (rst),
        .bus (mb)
    );

    modulator_am #(
        .FOO                  (1),
        .AM_CLKS_IN_PWM_STEPS (10),
        .AM_PWM_STEPS         (10)
    ) dut_fb (
        .clk (clk),
        .rst (rst),
        .bus (fb)
    );

    always #5 clk = ~clk;

    assign pwm_obs = use_fb ? fb.pwm : mb.pwm;

    // Expected high clocks per period: min(D,N)*C
    function automatic int exp_high(input int d, input int n, input int c);
        return ((d < n) ? d : n) * c;
    endfunction

    task automatic drive_strobe(input logic s, input logic [7:0] v);
        if (use_fb) begin
            fb.new_sample = s;
            fb.sample     = v;
        end else begin
            mb.new_sample = s;
            mb.sample     = v;
        end
    endtask

    // Runs whole periods from a known period start, popping one expectation per period
    task automatic measure(input string name, input int n, input int c, input int periods,
                           input int s1_at, input logic [7:0] s1_v,
                           input int s2_at, input logic [7:0] s2_v);
        int len;
        len = n * c;
        for (int p = 0; p < periods; p++) begin
            int exp_hi;
            int high;
            int wrong;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s_scoreboard p%0d: got empty queue, required an expectation", name, p);
                exp_hi = 0;
            end else begin
                exp_hi = exp_q.pop_front();
            end
            high  = 0;
            wrong = 0;
            for (int i = 0; i < len; i++) begin
                int t;
                t = p * len + i;
                if (t == s1_at) drive_strobe(1'b1, s1_v);
                else if (t == s2_at) drive_strobe(1'b1, s2_v);
                @(posedge clk);
                @(negedge clk);
                drive_strobe(1'b0, 8'h00);
                if (pwm_obs === 1'b1) high++;
                if (pwm_obs !== ((i < exp_hi) ? 1'b1 : 1'b0)) wrong++;
            end
            checks++;
            if (high !== exp_hi) begin
                errors++;
                $display("[TB] FAIL %s_high p%0d: got %0d high clocks, expected %0d", name, p, high, exp_hi);
            end
            checks++;
            if (wrong !== 0) begin
                errors++;
                $display("[TB] FAIL %s_shape p%0d: got %0d clocks off the expected waveform, expected 0", name, p, wrong);
            end
        end
    endtask

    task automatic restart(input logic [7:0] n, input logic [7:0] c);
        mb.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mb.bits_per_sample   = n;
        mb.clks_per_pwm_step = c;
        mb.enable            = 1'b1;
    endtask

    task automatic test_reset();
        rst                  = 1'b0;
        mb.enable            = 1'b1;
        mb.bits_per_sample   = 8'd4;
        mb.clks_per_pwm_step = 8'd3;
        mb.new_sample        = 1'b1;
        mb.sample            = 8'hFF;
        fb.enable            = 1'b0;
        fb.bits_per_sample   = 8'd0;
        fb.clks_per_pwm_step = 8'd0;
        fb.new_sample        = 1'b0;
        fb.sample            = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (mb.pwm !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_pwm c%0d: got %b, expected 0", k, mb.pwm);
            end
        end
        checks++;
        if (fb.pwm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pwm_fb: got %b, expected 0", fb.pwm);
        end
        rst           = 1'b1;
        mb.new_sample = 1'b0;
        // The strobe held during reset must not survive into pending
        exp_q.push_back(exp_high(0, 4, 3));
        exp_q.push_back(exp_high(0, 4, 3));
        measure("reset_idle", 4, 3, 2, -1, 8'd0, -1, 8'd0);
    endtask

    task automatic test_duty128();
        restart(8'd255, 8'd2);
        exp_q.push_back(exp_high(0, 255, 2));
        exp_q.push_back(exp_high(128, 255, 2));
        exp_q.push_back(exp_high(128, 255, 2));
        measure("duty128", 255, 2, 3, 0, 8'd128, -1, 8'd0);
    endtask

    task automatic test_duty_change();
        exp_q.push_back(exp_high(128, 255, 2));
        exp_q.push_back(exp_high(10, 255, 2));
        measure("duty_change", 255, 2, 2, 100, 8'd50, 300, 8'd10);
    endtask

    task automatic test_extremes();
        exp_q.push_back(exp_high(10, 255, 2));
        exp_q.push_back(exp_high(0, 255, 2));
        measure("duty_zero", 255, 2, 2, 0, 8'd0, -1, 8'd0);
        exp_q.push_back(exp_high(0, 255, 2));
        exp_q.push_back(exp_high(255, 255, 2));
        exp_q.push_back(exp_high(255, 255, 2));
        measure("duty_full", 255, 2, 3, 0, 8'd255, -1, 8'd0);
    endtask

    task automatic test_boundary();
        restart(8'd4, 8'd3);
        exp_q.push_back(exp_high(255, 4, 3));
        exp_q.push_back(exp_high(1, 4, 3));
        exp_q.push_back(exp_high(2, 4, 3));
        measure("boundary", 4, 3, 3, 11, 8'd2, 5, 8'd1);
        restart(8'd1, 8'd3);
        exp_q.push_back(exp_high(2, 1, 3));
        exp_q.push_back(exp_high(2, 1, 3));
        exp_q.push_back(exp_high(0, 1, 3));
        measure("one_step", 1, 3, 3, 2, 8'd0, -1, 8'd0);
        exp_q.push_back(exp_high(0, 1, 3));
        exp_q.push_back(exp_high(1, 1, 3));
        measure("one_step_d1", 1, 3, 2, 0, 8'd1, -1, 8'd0);
    endtask

    task automatic test_enable_gating();
        restart(8'd8, 8'd2);
        exp_q.push_back(exp_high(1, 8, 2));
        exp_q.push_back(exp_high(5, 8, 2));
        measure("gate_pre", 8, 2, 2, 0, 8'd5, -1, 8'd0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (mb.pwm !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gate_high: got %b, expected 1", mb.pwm);
        end
        mb.enable          = 1'b0;
        mb.bits_per_sample = 8'd6;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mb.pwm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gate_low: got %b, expected 0", mb.pwm);
        end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (mb.pwm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gate_hold: got %b, expected 0", mb.pwm);
        end
        mb.enable = 1'b1;
        exp_q.push_back(exp_high(5, 6, 2));
        exp_q.push_back(exp_high(5, 6, 2));
        measure("gate_resume", 6, 2, 2, -1, 8'd0, -1, 8'd0);
    endtask

    task automatic test_fallback();
        use_fb    = 1'b1;
        fb.enable = 1'b1;
        exp_q.push_back(exp_high(0, 10, 10));
        exp_q.push_back(exp_high(5, 10, 10));
        measure("fallback", 10, 10, 2, 0, 8'd5, -1, 8'd0);
        fb.enable = 1'b0;
        use_fb    = 1'b0;
    endtask

    initial begin
        $display("[TB] starting modulator_am bench");
        test_reset();
        test_duty128();
        test_duty_change();
        test_extremes();
        test_boundary();
        test_enable_gating();
        test_fallback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
